dff_bank_arbiter: RTL



---
 rtl/dff_bank_pkg.sv | 19 +
 rtl/dff_bank_arbiter_if.sv | 21 ++
 rtl/dff_en.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/dff_bank_arbiter.sv | 92 +++++++++
 5 files changed

// File: rtl/dff_bank_pkg.sv
// Shared types and defaults for the round-robin arbiter in front of the shared enabled register.
`timescale 1ns/1ps
package dff_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 8;

    // Requester index width; a 2-requester bank still needs one index bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests/data in, grant/ack/register state out.
`timescale 1ns/1ps
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IDX_W   = idx_w(NUM_REQ)
) ();
    logic                     hold;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         q;
    logic [IDX_W-1:0]         owner;
    logic                     busy;

    modport master (output hold, req, data, input gnt, ack, q, owner, busy);
    modport slave  (input hold, req, data, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/dff_en.sv
// Enabled D flip-flop with asynchronous active-high reset; one bit of the shared register.
`timescale 1ns/1ps
module dff_en (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= 1'b0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first asserted request at or above ptr, wrapping upward.
`timescale 1ns/1ps
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);
    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the closest hit overwrites the others.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pos    = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) pos = pos - (IDX_W + 1)'(NUM_REQ);
            cand = pos[IDX_W-1:0];
            if (req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time a single enabled write into a shared register.
`timescale 1ns/1ps
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input logic               clk,
    input logic               reset,
    dff_bank_arbiter_if.slave bus
);
    localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);
    localparam logic [IDX_W-1:0]   LAST = IDX_W'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_r, ack_r;
    logic [IDX_W-1:0]   ptr, win, owner_r, pick;
    logic               found, start, commit, busy_c;
    logic [WIDTH-1:0]   wdata, q_bits;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .found  (found),
        .winner (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   state_nxt = commit ? DONE : IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A winner that dropped req before the closing WRITE edge aborts without touching the register.
    always_comb begin
        start  = (state == IDLE) && !bus.hold && found;
        commit = (state == WRITE) && bus.req[win];
        busy_c = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r   <= '0;
            ack_r   <= '0;
            win     <= '0;
            ptr     <= '0;
            owner_r <= '0;
        end else begin
            ack_r <= '0;
            if (start) begin
                gnt_r <= ONE << pick;
                win   <= pick;
            end else if (state == WRITE) begin
                gnt_r <= '0;
            end
            if (commit) begin
                ack_r   <= ONE << win;
                owner_r <= win;
                ptr     <= (win == LAST) ? '0 : win + 1'b1;
            end
        end
    end

    assign wdata = bus.data[win*WIDTH +: WIDTH];

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        dff_en u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (commit),
            .d     (wdata[b]),
            .q     (q_bits[b])
        );
    end

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.q     = q_bits;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_c;
endmodule
